// File: rtl/gpio_out_mmio.sv
// Memory-mapped 8-bit output port with plain/set/clear/toggle writes and a timed-pulse engine.
// One-cycle Ack and registered readback for the multicycle core's data bus.
module gpio_out_mmio #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      GPIO_W    = 8,
    parameter logic [WIDTH-1:0] BASE_ADDR = 32'h1001_0020,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  Address,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic              MemWrite,
    input  logic              MemRead,
    output logic [WIDTH-1:0]  ReadData,
    output logic              Ack,
    output logic [GPIO_W-1:0] GPIO_o,
    output logic              Busy
);

    typedef enum logic {StIdle, StActive} state_e;

    state_e            state_q;
    logic [GPIO_W-1:0] out_q;
    logic [GPIO_W-1:0] mask_q;
    logic [CNT_W-1:0]  count_q;
    logic [WIDTH-1:0]  read_data_q;
    logic              ack_q;

    logic              hit;
    logic              wr_hit;
    logic              rd_hit;
    logic [2:0]        offset;
    logic [GPIO_W-1:0] wr_bits;
    logic [CNT_W-1:0]  pulse_len;
    logic              pulse_wr;
    logic [GPIO_W-1:0] bus_out;
    logic [WIDTH-1:0]  rd_val;
    logic              unused_wdata;

    assign hit       = (Address[WIDTH-1:5] == BASE_ADDR[WIDTH-1:5]) && (Address[1:0] == 2'b00);
    assign offset    = Address[4:2];
    assign wr_hit    = hit & MemWrite;
    // A combined read+write is treated purely as a write.
    assign rd_hit    = hit & MemRead & ~MemWrite;
    assign wr_bits   = WriteData[GPIO_W-1:0];
    assign pulse_len = WriteData[WIDTH-1 -: CNT_W];
    assign pulse_wr  = wr_hit && (offset == 3'd4);
    assign unused_wdata = ^WriteData;

    always_comb begin
        bus_out = out_q;
        if (wr_hit) begin
            case (offset)
                3'd0:    bus_out = wr_bits;
                3'd1:    bus_out = out_q | wr_bits;
                3'd2:    bus_out = out_q & ~wr_bits;
                3'd3:    bus_out = out_q ^ wr_bits;
                default: bus_out = out_q;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (offset)
            3'd0: rd_val[GPIO_W-1:0] = out_q;
            3'd4: begin
                rd_val[WIDTH-1]   = (state_q == StActive);
                rd_val[CNT_W-1:0] = count_q;
            end
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            out_q       <= '0;
            mask_q      <= '0;
            count_q     <= '0;
            read_data_q <= '0;
            ack_q       <= 1'b0;
        end else begin
            ack_q       <= hit & (MemWrite | MemRead);
            read_data_q <= rd_hit ? rd_val : '0;
            out_q       <= bus_out;
            case (state_q)
                StIdle: begin
                    if (pulse_wr && (pulse_len != '0)) begin
                        out_q   <= bus_out | wr_bits;
                        mask_q  <= wr_bits;
                        count_q <= pulse_len;
                        state_q <= StActive;
                    end
                end
                StActive: begin
                    if (count_q > CNT_W'(1)) begin
                        count_q <= count_q - CNT_W'(1);
                    end else begin
                        // Pulse end overrides any bus write landing on the same edge.
                        out_q   <= bus_out & ~mask_q;
                        count_q <= '0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ReadData = read_data_q;
    assign Ack      = ack_q;
    assign GPIO_o   = out_q;
    assign Busy     = (state_q == StActive);

endmodule

// File: tb/tb_gpio_out_mmio.sv
// Directed and random bench for gpio_out_mmio against an edge-by-edge behavioural model
// that tracks the pulse as an absolute end time rather than a down-counter.
module tb_gpio_out_mmio;

    localparam logic [31:0] BASE = 32'h1001_0020;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] ReadData;
    logic        Ack;
    logic [7:0]  GPIO_o;
    logic        Busy;

    gpio_out_mmio dut (
        .clk       (clk),
        .rst       (rst),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .Ack       (Ack),
        .GPIO_o    (GPIO_o),
        .Busy      (Busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: edge index, port value, and pulse as [start, m_end) in edge numbers.
    int          n = 0;
    logic [7:0]  m_out = '0;
    logic        m_active = 1'b0;
    int          m_end = 0;
    logic [7:0]  m_mask = '0;
    logic        m_ack = 1'b0;
    logic [31:0] m_rd = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic w,
                              input logic r);
        logic       hit;
        logic [2:0] off;
        logic [7:0] nxt;
        logic       start;
        int         len;
        hit   = (a[31:5] == BASE[31:5]) && (a[1:0] == 2'b00);
        off   = a[4:2];
        len   = int'(d[31:16]);
        m_ack = hit && (w || r);
        m_rd  = '0;
        if (hit && r && !w) begin
            if (off == 3'd0) m_rd = {24'b0, m_out};
            else if (off == 3'd4 && m_active) m_rd = 32'h8000_0000 | 32'(m_end - n + 1);
        end
        nxt   = m_out;
        start = 1'b0;
        if (hit && w) begin
            case (off)
                3'd0: nxt = d[7:0];
                3'd1: nxt = m_out | d[7:0];
                3'd2: nxt = m_out & ~d[7:0];
                3'd3: nxt = m_out ^ d[7:0];
                3'd4: start = !m_active && (len != 0);
                default: ;
            endcase
        end
        if (m_active && n == m_end) begin
            nxt &= ~m_mask;
            m_active = 1'b0;
        end else if (start) begin
            nxt |= d[7:0];
            m_mask = d[7:0];
            m_end = n + len;
            m_active = 1'b1;
        end
        m_out = nxt;
        n++;
    endtask

    task automatic check_all();
        chk("gpio", 32'(GPIO_o), 32'(m_out));
        chk("busy", 32'(Busy), 32'(m_active));
        chk("ack", 32'(Ack), 32'(m_ack));
        chk("rdata", ReadData, m_rd);
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        Address   = a;
        WriteData = d;
        MemWrite  = w;
        MemRead   = r;
        @(posedge clk);
        model_edge(a, d, w, r);
        #1;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        check_all();
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        step(BASE + off, d, 1'b1, 1'b0);
    endtask

    task automatic rd(input logic [31:0] off);
        step(BASE + off, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(BASE + 32'h40, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        m_out = '0; m_active = 1'b0; m_ack = 1'b0; m_rd = '0; m_mask = '0;
        n++;
        #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          sel;

        // Reset and basic register access.
        do_reset();
        idle();
        chk("reset_gpio", 32'(GPIO_o), 32'h0);
        wr(32'h0, 32'h0000_00A5);
        chk("data_wr", 32'(GPIO_o), 32'hA5);
        rd(32'h0);
        chk("data_rd", ReadData, 32'h0000_00A5);
        wr(32'h4, 32'h0F);
        chk("set", 32'(GPIO_o), 32'hAF);
        wr(32'h8, 32'hA0);
        chk("clr", 32'(GPIO_o), 32'h0F);
        wr(32'hC, 32'hFF);
        chk("tgl", 32'(GPIO_o), 32'hF0);
        wr(32'h14, 32'h55);
        chk("rsv_wr", 32'(GPIO_o), 32'hF0);
        rd(32'h14);
        rd(32'h4);

        // Pulse len=5 mask=0x03 with mid-pulse read and ignored retrigger.
        wr(32'h0, 32'h0);
        wr(32'h10, 32'h0005_0003);
        chk("pulse_on", 32'(GPIO_o), 32'h03);
        rd(32'h10);
        chk("pulse_rd", ReadData, 32'h8000_0005);
        rd(32'h10);
        wr(32'h10, 32'h0009_00F0);
        idle();
        chk("pulse_last", 32'(Busy), 32'h1);
        idle();
        chk("pulse_off", 32'(GPIO_o), 32'h00);
        idle();

        // Collision: SET on the terminating edge of a len=3 pulse.
        wr(32'h10, 32'h0003_0001);
        idle();
        idle();
        wr(32'h4, 32'h81);
        chk("collide", 32'(GPIO_o), 32'h80);
        wr(32'h10, 32'h0000_00FF);
        chk("len0", 32'(GPIO_o), 32'h80);

        // Reset in the middle of a pulse.
        wr(32'h0, 32'h0);
        wr(32'h10, 32'h0005_0003);
        idle();
        idle();
        idle();
        do_reset();
        chk("rst_mid", 32'(GPIO_o), 32'h0);
        rd(32'h10);
        chk("rst_rd", ReadData, 32'h0);

        // Out-of-window, misaligned, and combined read/write.
        step(BASE + 32'h20, 32'hFF, 1'b1, 1'b1);
        chk("outside", 32'(Ack), 32'h0);
        step(BASE + 32'h1, 32'hFF, 1'b1, 1'b0);
        step(BASE, 32'h3C, 1'b1, 1'b1);
        chk("combo", 32'(GPIO_o), 32'h3C);
        idle();
        chk("combo_ack1", 32'(Ack), 32'h0);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 8) a = BASE + 32'(sel * 4);
            else if (sel == 8) a = BASE + 32'h20;
            else a = BASE + 32'h2;
            d = {16'($urandom_range(0, 6)), 8'($urandom), 8'($urandom)};
            step(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
